mode_sequencer: RTL and testbench

- User-input controller that drives the counter's mode-select/limit register and sequences the counter around every mode change and limit capture.
- Converts two synchronised, debounced buttons into the following control signals:
  - level mode selects: carry_set, max_set
  - one-cycle refresh_limits and cnt_clear pulses
  - a cnt_hold freeze that covers the one-cycle register latency of the mode-select block.
- Sits between the input synchroniser/debouncer and the counter + mode-select blocks.

---
 rtl/mode_sequencer_pkg.sv | 35 +++
 rtl/mode_sequencer_press_classifier.sv | 54 +++++
 rtl/mode_sequencer.sv | 121 ++++++++++++
 tb/tb_mode_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mode_sequencer_pkg.sv
// Shared encodings and defaults for the mode sequencer and its press classifier.
package mode_sequencer_pkg;

    localparam int unsigned HOLD_CYCLES_DEF   = 24;
    localparam int unsigned SETTLE_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_CARRY  = 2'd1,
        MODE_MAX    = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SETTLE     = 3'd1,
        CAP_FREEZE = 3'd2,
        CAP_LOAD   = 3'd3,
        CAP_CLEAR  = 3'd4
    } fsm_e;

    // Without a valid limit only SINGLE is reachable.
    function automatic mode_e next_mode(input mode_e cur, input logic valid);
        mode_e nxt;
        nxt = MODE_SINGLE;
        if (valid) begin
            case (cur)
                MODE_SINGLE: nxt = MODE_CARRY;
                MODE_CARRY:  nxt = MODE_MAX;
                default:     nxt = MODE_SINGLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mode_sequencer_press_classifier.sv
// Classifies the set button into short-press and long-press strobes while enabled.
module mode_sequencer_press_classifier
    import mode_sequencer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic enable,
    output logic short_press,
    output logic long_press
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

    logic          btn_q;
    logic          consumed;
    logic [CW-1:0] hold_cnt;
    logic          fall;

    assign fall        = ~btn & btn_q;
    assign long_press  = enable & btn & (hold_cnt == HOLD_MAX) & ~consumed;
    assign short_press = enable & fall & ~consumed;

    // A press seen while disabled is marked consumed so it acts only after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q    <= 1'b0;
            consumed <= 1'b0;
            hold_cnt <= '0;
        end else begin
            btn_q <= btn;
            if (fall) begin
                hold_cnt <= '0;
                consumed <= 1'b0;
            end else if (btn) begin
                if (!enable) begin
                    hold_cnt <= '0;
                    consumed <= 1'b1;
                end else begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                    if (long_press) begin
                        consumed <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Turns mode/set buttons into mode selects and sequences counter hold/clear/limit load.
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int unsigned DIGITS        = 6,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_btn,
    input  logic                  set_btn,
    input  logic [4*DIGITS-1:0]   cnt_in,
    output logic                  carry_set,
    output logic                  max_set,
    output logic                  refresh_limits,
    output logic                  cnt_clear,
    output logic                  cnt_hold,
    output logic                  limit_valid,
    output logic [1:0]            mode
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);

    fsm_e          fsm, fsm_nxt;
    mode_e         mode_q, mode_nxt;
    logic          lv_nxt;
    logic [SW-1:0] settle_cnt, settle_nxt;
    logic          mode_btn_q;
    logic          mode_rise;
    logic          short_press, long_press;
    logic          short_clr;

    assign mode_rise = mode_btn & ~mode_btn_q;
    assign mode      = mode_q;

    mode_sequencer_press_classifier #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_press_classifier (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (set_btn),
        .enable     (fsm == RUN),
        .short_press(short_press),
        .long_press (long_press)
    );

    // State and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm            <= RUN;
            mode_q         <= MODE_SINGLE;
            limit_valid    <= 1'b0;
            settle_cnt     <= '0;
            mode_btn_q     <= 1'b0;
            carry_set      <= 1'b0;
            max_set        <= 1'b0;
            refresh_limits <= 1'b0;
            cnt_clear      <= 1'b0;
            cnt_hold       <= 1'b0;
        end else begin
            fsm            <= fsm_nxt;
            mode_q         <= mode_nxt;
            limit_valid    <= lv_nxt;
            settle_cnt     <= settle_nxt;
            mode_btn_q     <= mode_btn;
            carry_set      <= (mode_nxt == MODE_CARRY);
            max_set        <= (mode_nxt == MODE_MAX);
            refresh_limits <= (fsm_nxt == CAP_LOAD);
            cnt_clear      <= short_clr | (fsm_nxt == CAP_CLEAR);
            cnt_hold       <= (fsm_nxt != RUN);
        end
    end

    // Next-state logic; a long press outranks a same-cycle mode edge, which is dropped.
    always_comb begin
        fsm_nxt    = fsm;
        mode_nxt   = mode_q;
        lv_nxt     = limit_valid;
        settle_nxt = settle_cnt;
        short_clr  = 1'b0;
        case (fsm)
            RUN: begin
                short_clr = short_press;
                if (long_press) begin
                    fsm_nxt = CAP_FREEZE;
                end else if (mode_rise) begin
                    mode_nxt   = next_mode(mode_q, limit_valid);
                    fsm_nxt    = SETTLE;
                    settle_nxt = SETTLE_INIT;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    fsm_nxt = RUN;
                end else begin
                    settle_nxt = settle_cnt - SW'(1);
                end
            end
            CAP_FREEZE: begin
                fsm_nxt = CAP_LOAD;
            end
            CAP_LOAD: begin
                lv_nxt  = (cnt_in != '0);
                fsm_nxt = CAP_CLEAR;
            end
            CAP_CLEAR: begin
                if (!limit_valid && (mode_q != MODE_SINGLE)) begin
                    mode_nxt = MODE_SINGLE;
                end
                fsm_nxt    = SETTLE;
                settle_nxt = SETTLE_INIT;
            end
            default: begin
                fsm_nxt = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with HOLD_CYCLES=8, SETTLE_CYCLES=2, DIGITS=6.
module tb_mode_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mode_btn;
    logic        set_btn;
    logic [23:0] cnt_in;
    logic        carry_set;
    logic        max_set;
    logic        refresh_limits;
    logic        cnt_clear;
    logic        cnt_hold;
    logic        limit_valid;
    logic [1:0]  mode;

    int n_checks;
    int n_pass;

    mode_sequencer #(
        .DIGITS       (6),
        .HOLD_CYCLES  (8),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_btn      (mode_btn),
        .set_btn       (set_btn),
        .cnt_in        (cnt_in),
        .carry_set     (carry_set),
        .max_set       (max_set),
        .refresh_limits(refresh_limits),
        .cnt_clear     (cnt_clear),
        .cnt_hold      (cnt_hold),
        .limit_valid   (limit_valid),
        .mode          (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Vector order: carry, max, refresh, clear, hold, limit_valid, mode[1:0]
    task automatic chk(input string tag, input logic [1:0] m, input logic lv,
                       input logic hold, input logic clr, input logic refr);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {carry_set, max_set, refresh_limits, cnt_clear, cnt_hold, limit_valid, mode};
        exp = {(m == 2'd1), (m == 2'd2), refr, clr, hold, lv, m};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    logic [1:0] seq_mode [3];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        seq_mode = '{2'd1, 2'd2, 2'd0};
        rst_n    = 1'b0;
        mode_btn = 1'b0;
        set_btn  = 1'b0;
        cnt_in   = 24'h0;

        // Reset
        idle(2);
        chk("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mode press without a valid limit: stays SINGLE, holds 2 cycles
        mode_btn = 1'b1;
        tick();
        chk("nolim_hold1", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        mode_btn = 1'b0;
        tick();
        chk("nolim_hold2", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("nolim_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Long press capturing a nonzero limit
        cnt_in  = 24'h000123;
        set_btn = 1'b1;
        idle(7);
        chk("lp_pre", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lp_freeze", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("lp_load", 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("lp_clear", 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        set_btn = 1'b0;
        tick();
        chk("lp_settle1", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("lp_settle2", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("lp_run", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lp_no_release_clr", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Mode cycling with a valid limit
        for (int i = 0; i < 3; i++) begin
            mode_btn = 1'b1;
            tick();
            chk("mode_step", seq_mode[i], 1'b1, 1'b1, 1'b0, 1'b0);
            mode_btn = 1'b0;
            tick();
            chk("mode_hold2", seq_mode[i], 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            chk("mode_run", seq_mode[i], 1'b1, 1'b0, 1'b0, 1'b0);
            idle(2);
        end

        // Short press
        set_btn = 1'b1;
        idle(3);
        chk("sp_held", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_btn = 1'b0;
        tick();
        chk("sp_clear", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("sp_after", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reach MAX, then zero-limit capture with a colliding mode edge
        for (int i = 0; i < 2; i++) begin
            mode_btn = 1'b1;
            tick();
            mode_btn = 1'b0;
            idle(4);
        end
        chk("max_ready", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        cnt_in  = 24'h0;
        set_btn = 1'b1;
        idle(7);
        mode_btn = 1'b1;
        tick();
        chk("cap_wins", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        mode_btn = 1'b0;
        tick();
        chk("z_load", 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("z_clear", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        set_btn = 1'b0;
        tick();
        chk("z_forced_single", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("z_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Restore a limit, go to CARRY, then reset during CAP_LOAD
        cnt_in  = 24'h000500;
        set_btn = 1'b1;
        idle(10);
        set_btn = 1'b0;
        idle(4);
        chk("lv_restored", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        mode_btn = 1'b1;
        tick();
        mode_btn = 1'b0;
        idle(4);
        chk("carry_ready", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_btn = 1'b1;
        idle(9);
        chk("rst_pre_load", 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        rst_n   = 1'b0;
        set_btn = 1'b0;
        tick();
        chk("rst_mid_seq", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_after1", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_after2", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
